// File: rtl/if_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: reset vector, NOP encoding
// and the {pc, inst} record carried through the fetch buffer.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, inst} records with flush; the head entry is
// always presented, so the reset entry doubles as the idle decode output.
module fetch_buffer
    import if_stage_pkg::*;
#(
    parameter int           DEPTH       = 2,
    parameter fetch_entry_t RESET_ENTRY = {RESET_PC_DEFAULT, NOP_INST}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    localparam int PTR_W = 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    fetch_entry_t     entries [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (push && !flush && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = push_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= RESET_ENTRY;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign entries[gi] = entry_q;
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == 2'(DEPTH));
    assign empty = (count_q == 2'd0);
    assign head  = entries[rd_ptr_q];

    // Upstream flow control must never push into a full buffer or pop an empty one.
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                     !(push && full && !pop && !flush));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(pop && empty && !flush));
    a_count_range:  assert property (@(posedge clk) disable iff (!rst_n)
                                     count_q <= 2'(DEPTH));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one-cycle-latency memory reads, tracks the
// single outstanding request and buffers returned words for decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        i_rst_n,
    output logic [31:0] o_imem_raddr,
    output logic        o_imem_ren,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic [31:0]  redirect_target;
    logic         deq;
    logic         issue;
    logic         push;
    logic [2:0]   occupancy;
    fetch_entry_t push_entry;
    fetch_entry_t head;
    logic [1:0]   fb_count;
    logic         fb_full;
    logic         fb_empty;

    assign redirect_target = i_redirect_pc & ~32'h3;
    assign o_valid         = !fb_empty;
    assign deq             = o_valid && !i_stall && !i_redirect;

    // Slots already committed after this cycle: buffered words plus the pending response.
    assign occupancy  = {1'b0, fb_count} + {2'b00, inflight_q} - {2'b00, deq};
    // Gated by reset so no request leaks out while the block is held in reset.
    assign issue      = i_rst_n && !i_redirect && (occupancy < 3'd2);
    assign push       = inflight_q && !i_redirect;
    assign push_entry = {inflight_pc_q, i_imem_rdata};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (i_redirect) begin
            pc_d = redirect_target;
        end else if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q          <= RESET_PC_ALIGNED;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC_ALIGNED;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH       (FB_DEPTH),
        .RESET_ENTRY ({RESET_PC_ALIGNED, NOP_INST})
    ) u_fetch_buffer (
        .clk       (clk),
        .rst_n     (i_rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (deq),
        .flush     (i_redirect),
        .full      (fb_full),
        .empty     (fb_empty),
        .count     (fb_count),
        .head      (head)
    );

    assign o_imem_ren   = issue;
    assign o_imem_raddr = pc_q;
    assign o_inst       = head.inst;
    assign o_pc         = head.pc;

    a_full_blocks_issue: assert property (@(posedge clk) disable iff (!i_rst_n)
                                          (fb_full && !deq) |-> !issue);

endmodule
